// File: rtl/product_accumulator_if.sv
// Valid/ready bundle between a product sequencer (master) and the frame accumulator (slave).
// Also carries the synchronous frame-clear, which the sequencer owns.
interface product_accumulator_if #(
   parameter int P_WIDTH   = 6,
   parameter int ACC_WIDTH = 12
);
   logic                 clear;
   logic                 in_valid;
   logic                 in_ready;
   logic [P_WIDTH-1:0]   in_p;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_sum;
   logic                 out_ovf;

   modport master (
      output clear, in_valid, in_p, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  clear, in_valid, in_p, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );
endinterface

// File: rtl/product_accumulator.sv
// Sums frames of COUNT unsigned multiplier products and presents each frame total
// with a sticky carry-out flag on a valid/ready output.
module product_accumulator #(
   parameter int P_WIDTH   = 6,
   parameter int ACC_WIDTH = 12,
   parameter int COUNT     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   product_accumulator_if.slave  bus
);

   localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [ACC_WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_ovf;
   logic [ACC_WIDTH-1:0] r_out_sum;
   logic                 r_out_ovf;

   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_last;
   logic [ACC_WIDTH:0]   w_sum;
   logic                 w_new_ovf;

   // Sum with the carry-out kept in the extra top bit; the stored result wraps.
   function automatic logic [ACC_WIDTH:0] f_add_carry(
      input logic [ACC_WIDTH-1:0] acc,
      input logic [P_WIDTH-1:0]   p
   );
      return {1'b0, acc} + {{(ACC_WIDTH + 1 - P_WIDTH){1'b0}}, p};
   endfunction

   always_comb begin
      w_in_ready = (r_state == ACCUM) && !bus.clear;
      w_accept   = bus.in_valid && w_in_ready;
      w_last     = (r_cnt == CNT_W'(COUNT - 1));
      w_sum      = f_add_carry(r_acc, bus.in_p);
      w_new_ovf  = r_ovf | w_sum[ACC_WIDTH];
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ACCUM: if (w_accept && w_last) w_next_state = HOLD;
         HOLD:  if (bus.out_ready)      w_next_state = ACCUM;
      endcase
      if (bus.clear) w_next_state = ACCUM;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ACCUM;
      else     r_state <= w_next_state;
   end

   // Frame accumulator: the closing beat publishes the total and restarts the frame at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_out_sum <= '0;
         r_out_ovf <= 1'b0;
      end else if (bus.clear) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         if (w_last) begin
            r_out_sum <= w_sum[ACC_WIDTH-1:0];
            r_out_ovf <= w_new_ovf;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
         end else begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= w_new_ovf;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == HOLD);
   assign bus.out_sum   = r_out_sum;
   assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default instance plus an 8-bit, 8-beat instance
// for the wrap/overflow case.
module tb_product_accumulator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   product_accumulator_if #(.P_WIDTH(6), .ACC_WIDTH(12)) ia ();
   product_accumulator_if #(.P_WIDTH(6), .ACC_WIDTH(8))  ib ();

   product_accumulator #(.P_WIDTH(6), .ACC_WIDTH(12), .COUNT(4)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ia)
   );

   product_accumulator #(.P_WIDTH(6), .ACC_WIDTH(8), .COUNT(8)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ib)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_a(input logic [5:0] p);
      ia.in_valid = 1'b1;
      ia.in_p     = p;
      tick();
      ia.in_valid = 1'b0;
   endtask

   task automatic beat_b(input logic [5:0] p);
      ib.in_valid = 1'b1;
      ib.in_p     = p;
      tick();
      ib.in_valid = 1'b0;
   endtask

   initial begin
      logic [5:0] v_basic [4];
      v_basic = '{6'd15, 6'd12, 6'd49, 6'd0};

      ia.clear = 1'b0; ia.in_valid = 1'b0; ia.in_p = '0; ia.out_ready = 1'b1;
      ib.clear = 1'b0; ib.in_valid = 1'b0; ib.in_p = '0; ib.out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid", ia.out_valid, 0);
      chk("rst_out_sum", ia.out_sum, 0);
      chk("rst_out_ovf", ia.out_ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rst_in_ready", ia.in_ready, 1);

      // Basic back-to-back frame
      for (int i = 0; i < 4; i++) beat_a(v_basic[i]);
      chk("basic_out_valid", ia.out_valid, 1);
      chk("basic_out_sum", ia.out_sum, 76);
      chk("basic_out_ovf", ia.out_ovf, 0);
      chk("basic_in_ready_hold", ia.in_ready, 0);
      tick();
      chk("basic_valid_drop", ia.out_valid, 0);
      chk("basic_in_ready_back", ia.in_ready, 1);

      // Gaps between beats
      for (int i = 0; i < 4; i++) begin
         beat_a(v_basic[i]);
         if (i < 3) begin
            chk("gap_no_early_valid", ia.out_valid, 0);
            tick();
            tick();
            chk("gap_still_no_valid", ia.out_valid, 0);
         end
      end
      chk("gap_out_valid", ia.out_valid, 1);
      chk("gap_out_sum", ia.out_sum, 76);
      tick();

      // Backpressure with ignored extra input
      ia.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) beat_a(6'd49);
      for (int i = 0; i < 5; i++) begin
         ia.in_valid = 1'b1;
         ia.in_p     = 6'd3;
         #1;
         chk("bp_out_valid", ia.out_valid, 1);
         chk("bp_out_sum", ia.out_sum, 196);
         chk("bp_in_ready", ia.in_ready, 0);
         tick();
      end
      ia.in_valid  = 1'b0;
      ia.out_ready = 1'b1;
      tick();
      chk("bp_release_valid", ia.out_valid, 0);
      chk("bp_release_in_ready", ia.in_ready, 1);
      for (int i = 0; i < 4; i++) beat_a(6'd1);
      chk("bp_next_frame_sum", ia.out_sum, 4);
      tick();

      // Overflow on the 8-bit, 8-beat instance
      for (int i = 0; i < 8; i++) beat_b(6'd49);
      chk("ovf_out_valid", ib.out_valid, 1);
      chk("ovf_out_sum", ib.out_sum, 136);
      chk("ovf_out_ovf", ib.out_ovf, 1);
      tick();
      for (int i = 0; i < 8; i++) beat_b(6'd1);
      chk("ovf_next_sum", ib.out_sum, 8);
      chk("ovf_next_ovf", ib.out_ovf, 0);
      tick();

      // Clear mid-frame blocks the simultaneous beat
      beat_a(6'd7);
      beat_a(6'd7);
      ia.clear    = 1'b1;
      ia.in_valid = 1'b1;
      ia.in_p     = 6'd5;
      #1;
      chk("clr_in_ready", ia.in_ready, 0);
      tick();
      ia.clear    = 1'b0;
      ia.in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) beat_a(6'(i));
      chk("clr_frame_valid", ia.out_valid, 1);
      chk("clr_frame_sum", ia.out_sum, 10);
      tick();

      // Clear during HOLD discards the pending frame
      ia.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) beat_a(6'd1);
      chk("clr_hold_valid_before", ia.out_valid, 1);
      ia.clear = 1'b1;
      tick();
      ia.clear = 1'b0;
      #1;
      chk("clr_hold_valid_after", ia.out_valid, 0);
      chk("clr_hold_in_ready", ia.in_ready, 1);
      ia.out_ready = 1'b1;

      // Asynchronous reset mid-frame
      for (int i = 0; i < 3; i++) beat_a(6'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", ia.out_valid, 0);
      chk("arst_out_sum", ia.out_sum, 0);
      chk("arst_out_ovf", ia.out_ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) beat_a(6'd1);
      chk("arst_frame_valid", ia.out_valid, 1);
      chk("arst_frame_sum", ia.out_sum, 4);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
